// File: rtl/alu_acc.sv
// Accumulator ALU: single-cycle logic/arith ops on acc (A) and din (B), start/busy/done handshake.
// Define ALU_MUL_EN to compile in the multi-cycle shift-add multiply (op 12); otherwise op 12 is a NOP.
module alu_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [3:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] acc_hi,
  output logic [3:0]       flags
);

  // state  | meaning
  // IDLE   | waiting for start
  // EXEC   | single-cycle op, result written on leaving
  // MUL    | shift-add multiply, one partial product per cycle
  // DONE   | done pulse, result and flags valid

  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_INC  = 4'd10;
  localparam logic [3:0] OP_DEC  = 4'd11;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
`ifdef ALU_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic             c_nxt;
  logic             v_nxt;
  logic             upd;

  always_comb begin
    opb   = (op_q == OP_INC || op_q == OP_DEC) ? WIDTH'(1) : din;
    add_s = {1'b0, acc} + {1'b0, opb};
    sub_s = {1'b0, acc} - {1'b0, opb};
    res   = acc;
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    upd   = 1'b1;
    case (op_q)
      OP_LOAD: res = din;
      OP_ADD, OP_INC: begin
        res   = add_s[WIDTH-1:0];
        c_nxt = add_s[WIDTH];
        v_nxt = (acc[MSB] == opb[MSB]) && (add_s[MSB] != acc[MSB]);
      end
      // sub_s[WIDTH] is the borrow: set when acc < opb unsigned
      OP_SUB, OP_DEC: begin
        res   = sub_s[WIDTH-1:0];
        c_nxt = sub_s[WIDTH];
        v_nxt = (acc[MSB] != opb[MSB]) && (sub_s[MSB] != acc[MSB]);
      end
      OP_AND: res = acc & din;
      OP_OR:  res = acc | din;
      OP_XOR: res = acc ^ din;
      OP_NOT: res = ~acc;
      OP_SHL: begin
        res   = {acc[WIDTH-2:0], 1'b0};
        c_nxt = acc[MSB];
      end
      OP_SHR: begin
        res   = {1'b0, acc[WIDTH-1:1]};
        c_nxt = acc[0];
      end
      default: upd = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  // acc stays untouched during MUL, so it serves directly as the multiplicand
  logic [WIDTH-1:0]   prod_hi;
  logic [WIDTH-1:0]   prod_lo;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     mul_s;
  logic [2*WIDTH-1:0] prod_nxt;

  always_comb begin
    mul_s    = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, acc} : {(WIDTH+1){1'b0}});
    prod_nxt = {mul_s, prod_lo[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc     <= '0;
      acc_hi  <= '0;
      flags   <= '0;
`ifdef ALU_MUL_EN
      prod_hi <= '0;
      prod_lo <= '0;
      cnt     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            busy <= 1'b1;
`ifdef ALU_MUL_EN
            if (op == OP_MUL) begin
              state   <= S_MUL;
              prod_hi <= '0;
              prod_lo <= din;
              cnt     <= CW'(WIDTH - 1);
            end else begin
              state <= S_EXEC;
            end
`else
            state <= S_EXEC;
`endif
          end
        end
        S_EXEC: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (upd) begin
            acc    <= res;
            acc_hi <= '0;
            flags  <= {res[MSB], v_nxt, c_nxt, (res == '0)};
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          {prod_hi, prod_lo} <= prod_nxt;
          if (cnt == '0) begin
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            acc    <= prod_nxt[WIDTH-1:0];
            acc_hi <= prod_nxt[2*WIDTH-1:WIDTH];
            flags  <= {prod_nxt[2*WIDTH-1], 1'b0, (prod_nxt[2*WIDTH-1:WIDTH] != '0),
                       (prod_nxt == '0)};
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_acc.sv
// Directed table-driven bench for alu_acc; expectations follow ALU_MUL_EN when defined.
module tb_alu_acc;
  localparam int W = 8;

  localparam logic [3:0] NOP  = 4'd0;
  localparam logic [3:0] LOAD = 4'd1;
  localparam logic [3:0] ADD  = 4'd2;
  localparam logic [3:0] SUB  = 4'd3;
  localparam logic [3:0] AND_ = 4'd4;
  localparam logic [3:0] OR_  = 4'd5;
  localparam logic [3:0] XOR_ = 4'd6;
  localparam logic [3:0] NOT_ = 4'd7;
  localparam logic [3:0] SHL  = 4'd8;
  localparam logic [3:0] SHR  = 4'd9;
  localparam logic [3:0] INC  = 4'd10;
  localparam logic [3:0] DEC  = 4'd11;
  localparam logic [3:0] MUL  = 4'd12;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [3:0]   op;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] acc;
  logic [W-1:0] acc_hi;
  logic [3:0]   flags;

  int checks   = 0;
  int failures = 0;

  alu_acc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .op    (op),
    .start (start),
    .busy  (busy),
    .done  (done),
    .acc   (acc),
    .acc_hi(acc_hi),
    .flags (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] din;
    logic [7:0] acc;
    logic [7:0] hi;
    logic [3:0] fl;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] o, input logic [7:0] d, input logic [7:0] a,
                     input logic [7:0] h, input logic [3:0] f, input int l);
    vec_t v;
    v.op = o; v.din = d; v.acc = a; v.hi = h; v.fl = f; v.lat = l;
    vecs.push_back(v);
  endtask

  // Issues one op and waits for done; lat counts negedges from start to done.
  task automatic run_op(input logic [3:0] o, input logic [7:0] d, output int lat, output int nbusy);
    lat = 0;
    nbusy = 0;
    @(negedge clk);
    start = 1'b1; op = o; din = d;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) nbusy++;
    end while (!done && lat < 40);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout op=%0d actual=no_done required=done", o);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, ndone;
    rst = 1'b0; start = 1'b0; op = '0; din = '0;
    repeat (3) @(negedge clk);
    chk("rst_acc", acc, 0);
    chk("rst_hi", acc_hi, 0);
    chk("rst_flags", flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // flags = {N,V,C,Z}
    add(LOAD, 8'h7F, 8'h7F, 8'h00, 4'b0000, 2);
    add(INC,  8'h00, 8'h80, 8'h00, 4'b1100, 2);
    add(LOAD, 8'hFF, 8'hFF, 8'h00, 4'b1000, 2);
    add(ADD,  8'h01, 8'h00, 8'h00, 4'b0011, 2);
    add(SUB,  8'h01, 8'hFF, 8'h00, 4'b1010, 2);
    add(AND_, 8'h0F, 8'h0F, 8'h00, 4'b0000, 2);
    add(OR_,  8'hF0, 8'hFF, 8'h00, 4'b1000, 2);
    add(XOR_, 8'h0F, 8'hF0, 8'h00, 4'b1000, 2);
    add(NOT_, 8'h00, 8'h0F, 8'h00, 4'b0000, 2);
    add(LOAD, 8'h81, 8'h81, 8'h00, 4'b1000, 2);
    add(SHL,  8'h00, 8'h02, 8'h00, 4'b0010, 2);
    add(LOAD, 8'h03, 8'h03, 8'h00, 4'b0000, 2);
    add(SHR,  8'h00, 8'h01, 8'h00, 4'b0010, 2);
    add(DEC,  8'h00, 8'h00, 8'h00, 4'b0001, 2);
    add(DEC,  8'h00, 8'hFF, 8'h00, 4'b1010, 2);
    add(LOAD, 8'h80, 8'h80, 8'h00, 4'b1000, 2);
    add(DEC,  8'h00, 8'h7F, 8'h00, 4'b0100, 2);
    add(LOAD, 8'h80, 8'h80, 8'h00, 4'b1000, 2);
    add(ADD,  8'h80, 8'h00, 8'h00, 4'b0111, 2);
    add(NOP,  8'h55, 8'h00, 8'h00, 4'b0111, 2);
    add(4'd14, 8'h55, 8'h00, 8'h00, 4'b0111, 2);
    add(LOAD, 8'hFF, 8'hFF, 8'h00, 4'b1000, 2);
`ifdef ALU_MUL_EN
    add(MUL,  8'hFF, 8'h01, 8'hFE, 4'b1010, 9);
    add(ADD,  8'h01, 8'h02, 8'h00, 4'b0000, 2);
    add(LOAD, 8'h05, 8'h05, 8'h00, 4'b0000, 2);
    add(MUL,  8'h03, 8'h0F, 8'h00, 4'b0000, 9);
    add(MUL,  8'h00, 8'h00, 8'h00, 4'b0001, 9);
`else
    add(MUL,  8'hFF, 8'hFF, 8'h00, 4'b1000, 2);
    add(ADD,  8'h01, 8'h00, 8'h00, 4'b0011, 2);
    add(LOAD, 8'h05, 8'h05, 8'h00, 4'b0000, 2);
    add(MUL,  8'h03, 8'h05, 8'h00, 4'b0000, 2);
    add(MUL,  8'h00, 8'h05, 8'h00, 4'b0000, 2);
`endif

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].din, lat, nb);
      chk($sformatf("v%0d_acc", i), acc, vecs[i].acc);
      chk($sformatf("v%0d_hi", i), acc_hi, vecs[i].hi);
      chk($sformatf("v%0d_flags", i), flags, vecs[i].fl);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_busy_cycles", i), nb, vecs[i].lat - 1);
    end

    // start held high across the whole op: only one INC may happen
    run_op(LOAD, 8'h10, lat, nb);
    @(negedge clk);
    start = 1'b1; op = INC; din = 8'h00;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("held_start_done_count", ndone, 1);
    chk("held_start_acc", acc, 8'h11);
    chk("held_start_flags", flags, 4'b0000);

    // async reset while an op (MUL when enabled) is in flight
    run_op(LOAD, 8'hFF, lat, nb);
    @(negedge clk);
    start = 1'b1; op = MUL; din = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("midop_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("midop_rst_acc", acc, 0);
    chk("midop_rst_hi", acc_hi, 0);
    chk("midop_rst_flags", flags, 0);
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("midop_no_done_after_rst", ndone, 0);
    chk("midop_acc_after", acc, 0);

    run_op(LOAD, 8'h42, lat, nb);
    chk("post_rst_acc", acc, 8'h42);
    chk("post_rst_lat", lat, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
